// File: rtl/armv8_pkg.sv
// Shared ARMv8 pipeline constants used by fetch, decode and hazard logic.
package armv8_pkg;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;
  localparam logic [ADDR_W-1:0]  PC_STEP   = 64'd4;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus plus the IF/ID register contents handed to decode.
interface fetch_stage_if;
  import armv8_pkg::*;

  logic [ADDR_W-1:0]  imemAddr;
  logic [INSTR_W-1:0] imemData;
  logic [ADDR_W-1:0]  ifidPC;
  logic [INSTR_W-1:0] ifidInstr;
  logic               ifidValid;

  modport master (
    output imemAddr, ifidPC, ifidInstr, ifidValid,
    input  imemData
  );

  modport slave (
    input  imemAddr, ifidPC, ifidInstr, ifidValid,
    output imemData
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load/hold/flush control and a saturating delivery counter.
module if_id_reg
  import armv8_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               flush,
  input  logic               load,
  input  logic [ADDR_W-1:0]  inPC,
  input  logic [INSTR_W-1:0] inInstr,
  input  logic               inValid,
  output logic [ADDR_W-1:0]  ifidPC,
  output logic [INSTR_W-1:0] ifidInstr,
  output logic               ifidValid,
  output logic [15:0]        fetchCount
);

  // Flush beats load so a redirect discards the word fetched in the same cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ifidPC     <= '0;
      ifidInstr  <= NOP_INSTR;
      ifidValid  <= 1'b0;
      fetchCount <= '0;
    end else if (flush) begin
      ifidPC     <= inPC;
      ifidInstr  <= NOP_INSTR;
      ifidValid  <= 1'b0;
    end else if (load) begin
      ifidPC     <= inPC;
      ifidInstr  <= inValid ? inInstr : NOP_INSTR;
      ifidValid  <= inValid;
      if (inValid && fetchCount != 16'hFFFF) begin
        fetchCount <= fetchCount + 16'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ARMv8 instruction-fetch stage: PC register, next-PC selection and imem range check.
module fetch_stage
  import armv8_pkg::*;
#(
  parameter int IMEM_WORDS = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] startPC,
  input  logic              stall,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  output logic [ADDR_W-1:0] currentPC,
  output logic [15:0]       fetchCount,
  fetch_stage_if.master     bus
);

  localparam logic [ADDR_W-1:0] IMEM_BYTES = ADDR_W'(IMEM_WORDS * 4);

  logic [ADDR_W-1:0]  pc;
  logic               inRange;
  logic [ADDR_W-1:0]  ifidPC;
  logic [INSTR_W-1:0] ifidInstr;
  logic               ifidValid;

  // Redirect wins over stall; PC+4 wraps freely at the top of the address space.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc <= align_pc(startPC);
    end else if (branchTaken) begin
      pc <= align_pc(branchTarget);
    end else if (!stall) begin
      pc <= pc + PC_STEP;
    end
  end

  assign inRange      = (pc < IMEM_BYTES);
  assign currentPC    = pc;
  assign bus.imemAddr = pc;

  if_id_reg u_if_id_reg (
    .Clk        (Clk),
    .Rst        (Rst),
    .flush      (branchTaken),
    .load       (!stall),
    .inPC       (pc),
    .inInstr    (bus.imemData),
    .inValid    (inRange),
    .ifidPC     (ifidPC),
    .ifidInstr  (ifidInstr),
    .ifidValid  (ifidValid),
    .fetchCount (fetchCount)
  );

  assign bus.ifidPC    = ifidPC;
  assign bus.ifidInstr = ifidInstr;
  assign bus.ifidValid = ifidValid;

endmodule
